// File: rtl/contador_ocupacao_pkg.sv
// Shared definitions for the occupancy counter and the flow controller:
// debounce state encoding and default lot/debounce constants.
package contador_ocupacao_pkg;

    typedef enum logic [1:0] {
        BAIXO,
        SUBINDO,
        ALTO,
        DESCENDO
    } estado_deb_t;

    localparam int unsigned CAPACITY_PADRAO   = 8;
    localparam int unsigned DEB_CYCLES_PADRAO = 4;

endpackage

// File: rtl/contador_ocupacao_filtro_sensor.sv
// filtro_sensor: 2-flop synchronizer followed by a debounce FSM for one raw
// sensor. Emits a 1-cycle pulse when a rise is accepted and the debounced level.
module filtro_sensor
    import contador_ocupacao_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic bruto,
    output logic pulso_subida,
    output logic nivel
);

    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sinc;
    logic          amostra;
    estado_deb_t   estado;
    logic [CW-1:0] cnt;

    generate
        if (DEB_CYCLES < 2) begin : g_chk_deb
            $error("filtro_sensor: DEB_CYCLES must be at least 2");
        end
    endgenerate

    assign amostra = sinc[1];

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) sinc <= '0;
        else       sinc <= {sinc[0], bruto};
    end

    // Debounce: a level is accepted after DEB_CYCLES consecutive equal samples;
    // cnt holds the number of samples already seen in the current run.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= BAIXO;
            cnt          <= '0;
            pulso_subida <= 1'b0;
            nivel        <= 1'b0;
        end else begin
            pulso_subida <= 1'b0;
            case (estado)
                BAIXO: begin
                    if (amostra) begin
                        estado <= SUBINDO;
                        cnt    <= CW'(1);
                    end
                end
                SUBINDO: begin
                    if (!amostra) begin
                        estado <= BAIXO;
                    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                        estado       <= ALTO;
                        nivel        <= 1'b1;
                        pulso_subida <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ALTO: begin
                    if (!amostra) begin
                        estado <= DESCENDO;
                        cnt    <= CW'(1);
                    end
                end
                DESCENDO: begin
                    if (amostra) begin
                        estado <= ALTO;
                    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                        estado <= BAIXO;
                        nivel  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: estado <= BAIXO;
            endcase
        end
    end

endmodule

// File: rtl/contador_ocupacao.sv
// contador_ocupacao: debounces the entry (SE) and exit (SI) sensors and keeps
// a saturating lot occupancy count with Full/Contador/Erro flags.
// Optional almost-full flag enabled by defining CONTADOR_QUASE_CHEIO_EN.
module contador_ocupacao
    import contador_ocupacao_pkg::*;
#(
    parameter int unsigned CAPACITY      = CAPACITY_PADRAO,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_PADRAO,
    parameter int unsigned ALMOST_MARGIN = 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             SE,
    input  logic             SI,
    input  logic             Liberado,
    output logic             Full,
    output logic             Contador,
    output logic [CNT_W-1:0] ocupacao,
    output logic             Erro,
    output logic             QuaseCheio
);

    logic             pulso_se;
    logic             pulso_si;
    logic             entra;
    logic             sai;
    logic [CNT_W-1:0] prox;
    logic             erro_ev;

    generate
        if ((2 ** CNT_W) <= CAPACITY) begin : g_chk_w
            $error("contador_ocupacao: CNT_W too narrow for CAPACITY");
        end
        if (ALMOST_MARGIN > CAPACITY) begin : g_chk_m
            $error("contador_ocupacao: ALMOST_MARGIN exceeds CAPACITY");
        end
    endgenerate

    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_se (
        .clk          (CLK),
        .reset        (reset),
        .bruto        (SE),
        .pulso_subida (pulso_se),
        .nivel        ()
    );

    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_si (
        .clk          (CLK),
        .reset        (reset),
        .bruto        (SI),
        .pulso_subida (pulso_si),
        .nivel        ()
    );

    assign entra = pulso_se & Liberado;
    assign sai   = pulso_si;

    // Next occupancy and error event; a simultaneous entry+exit cancels unless
    // the lot is full, where only the exit is effective.
    always_comb begin
        prox    = ocupacao;
        erro_ev = 1'b0;
        if (entra && sai) begin
            if (ocupacao == CNT_W'(CAPACITY)) prox = ocupacao - CNT_W'(1);
        end else if (entra) begin
            if (ocupacao < CNT_W'(CAPACITY)) prox = ocupacao + CNT_W'(1);
            else                             erro_ev = 1'b1;
        end else if (sai) begin
            if (ocupacao != '0) prox = ocupacao - CNT_W'(1);
            else                erro_ev = 1'b1;
        end
    end

    // Occupancy register; flags derive from the next value so they track it.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ocupacao <= '0;
            Full     <= 1'b0;
            Contador <= 1'b0;
            Erro     <= 1'b0;
        end else begin
            ocupacao <= prox;
            Full     <= (prox == CNT_W'(CAPACITY));
            Contador <= (prox != '0);
            Erro     <= Erro | erro_ev;
        end
    end

`ifdef CONTADOR_QUASE_CHEIO_EN
    // Almost-full flag, registered alongside Full.
    always_ff @(posedge CLK) begin
        if (reset) QuaseCheio <= 1'b0;
        else       QuaseCheio <= (prox >= CNT_W'(CAPACITY - ALMOST_MARGIN));
    end
`else
    assign QuaseCheio = 1'b0;
`endif

endmodule
